// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaled time base, edge or center
// aligned counting, double-buffered duty registers and per-channel polarity.
module pwm_multi #(
    parameter int N          = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 16,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  center,
    input  logic [CHANNELS-1:0]   polarity,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [N-1:0]          wr_duty,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_start
);

    typedef enum logic {UP, DOWN} dir_t;

    localparam logic [N-1:0]    TOP     = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0]    ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CH_W:0]   NUM_CH  = (CH_W+1)'(CHANNELS);

    logic [PRESCALE_W-1:0] pre;
    logic [N-1:0]          cnt;
    dir_t                  dir;
    logic                  mode_q;
    logic                  bnd_q;
    logic [N-1:0]          shadow [CHANNELS];
    logic [N-1:0]          active [CHANNELS];

    logic                  tick;
    logic                  wrap;
    logic                  boundary;
    logic [N-1:0]          cnt_nxt;
    dir_t                  dir_nxt;
    logic [CHANNELS-1:0]   raw;

    assign tick     = ena && (pre >= prescale);
    assign boundary = tick && wrap;

    always_comb begin
        cnt_nxt = cnt + ONE;
        dir_nxt = dir;
        wrap    = 1'b0;
        if (!mode_q) begin
            dir_nxt = UP;
            if (cnt == TOP) begin
                cnt_nxt = '0;
                wrap    = 1'b1;
            end
        end else if (dir == UP) begin
            if (cnt == TOP) begin
                cnt_nxt = TOP - ONE;
                dir_nxt = DOWN;
            end
        end else begin
            cnt_nxt = cnt - ONE;
            if (cnt == ONE) begin
                dir_nxt = UP;
                wrap    = 1'b1;
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            raw[i] = (cnt < active[i]);
        end
    end

    // The boundary is registered once more so period_start lines up with the
    // first out value of the new period (out itself lags cnt by one clk).
    always_ff @(posedge clk) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= '0;
            dir          <= UP;
            mode_q       <= 1'b0;
            bnd_q        <= 1'b0;
            period_start <= 1'b0;
            out          <= '0;
            shadow       <= '{default: '0};
            active       <= '{default: '0};
        end else begin
            out          <= ena ? (raw ^ polarity) : polarity;
            period_start <= ena && bnd_q;
            if (wr_en && ({1'b0, wr_ch} < NUM_CH)) begin
                shadow[wr_ch] <= wr_duty;
            end
            if (!ena) begin
                pre    <= '0;
                cnt    <= '0;
                dir    <= UP;
                bnd_q  <= 1'b0;
                mode_q <= center;
                active <= shadow;
            end else begin
                if (tick) begin
                    pre <= '0;
                    cnt <= cnt_nxt;
                    dir <= dir_nxt;
                end else begin
                    pre <= pre + 1'b1;
                end
                bnd_q <= boundary;
                if (boundary) begin
                    mode_q <= center;
                    active <= shadow;
                end
            end
        end
    end

endmodule
